// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep driver: FSM state encoding, vector count
// and reference truth tables indexed by {a,b}.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned NUM_VEC = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_sweep_timer.sv
// Loadable down-counter used to time the settle interval of each vector.
module gate_sweep_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_driver.sv
// Sweeps a 2-input gate through 00,01,10,11 and checks c against EXP_TT.
// GATE_SWEEP_AUTORESTART_EN: when defined, sweeps repeat back-to-back after the first start.
module gate_sweep_driver
  import gate_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [3:0]  EXP_TT      = 4'b1000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

  if (HOLD_CYCLES < 1) begin : g_hold_chk
    $error("gate_sweep_driver: HOLD_CYCLES must be >= 1");
  end
  if ((CNT_W < 32) && (HOLD_CYCLES >= (32'd1 << CNT_W))) begin : g_cnt_chk
    $error("gate_sweep_driver: CNT_W too narrow for HOLD_CYCLES");
  end

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       tmr_load, tmr_en, tmr_zero;

  gate_sweep_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (RELOAD),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d    = '0;
          pass_d   = 1'b0;
          vec_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) state_d = ST_SAMPLE;
        else          tmr_en  = 1'b1;
      end
      ST_SAMPLE: begin
        if (gate_c != EXP_TT[vec_q]) err_d = err_q + 3'd1;
        if (vec_q != 2'd3) begin
          vec_d    = vec_q + 2'd1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end else begin
          // pass/done are registered on DONE entry so they line up with the DONE cycle
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef GATE_SWEEP_AUTORESTART_EN
        vec_d    = '0;
        err_d    = '0;
        busy_d   = 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_SETTLE;
`else
        state_d  = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign gate_a    = vec_q[1];
  assign gate_b    = vec_q[0];
  assign vec_idx   = vec_q;
  assign err_count = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_sweep_driver.sv
// Randomized directed bench for gate_sweep_driver with a cycle-level timing/truth-table model.
module tb_gate_sweep_driver;
  import gate_sweep_pkg::*;

`ifdef GATE_SWEEP_AUTORESTART_EN
  localparam int H = 1;
`else
  localparam int H = 10;
`endif
  localparam logic [3:0] EXP    = TT_AND;
  localparam int         SLOT   = H + 1;
  localparam int         DONE_C = 4 * SLOT + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       gate_c = 1'b0;
  logic       gate_a, gate_b, busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] vec_idx;

  int passed = 0;
  int total  = 0;

  gate_sweep_driver #(
    .HOLD_CYCLES (H),
    .EXP_TT      (EXP),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .gate_c    (gate_c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_idx   (vec_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs_vec();
    return {busy, done, pass, err_count, vec_idx, gate_a, gate_b};
  endfunction

  function automatic logic [10:0] pack(bit b, bit d, bit p, int e, int v);
    logic [1:0] vv;
    vv = v[1:0];
    return {b, d, p, e[2:0], vv, vv[1], vv[0]};
  endfunction

  // Mismatches the checker has seen by sweep cycle c (vector v is sampled in cycle (v+1)*SLOT).
  function automatic int exp_err(logic [3:0] tt, int c);
    int n = 0;
    for (int v = 0; v < 4; v++)
      if (((v + 1) * SLOT < c) && (tt[v] != EXP[v])) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input int c, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d got{busy,done,pass,err,vec,a,b}=%b want=%b", tag, c, obs, exp);
  endtask

  task automatic sweep(input string tag, input logic [3:0] tt, input bit glitch,
                       input bit repulse, input int rst_at);
    int v, e;
    logic [10:0] ex;
    @(negedge clk);
    start  = 1'b1;
    gate_c = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= DONE_C + 1; c++) begin
      v = (c - 1) / SLOT;
      if (v > 3) v = 3;
      e = exp_err(tt, c);
      if (c < DONE_C)       ex = pack(1, 0, 0, e, v);
      else if (c == DONE_C) ex = pack(0, 1, (e == 0), e, 3);
      else                  ex = pack(0, 0, (e == 0), e, 3);
      chk(tag, c, obs_vec(), ex);
      if ((c % SLOT == 0) && (c <= 4 * SLOT)) gate_c = tt[c / SLOT - 1];
      else if (glitch)                        gate_c = 1'($urandom);
      else                                    gate_c = tt[{gate_a, gate_b}];
      start = repulse && ((c == SLOT + 3) || (c == DONE_C));
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 2 * SLOT; k++) begin
          chk({tag, "_rst"}, k, obs_vec(), pack(0, 0, 0, 0, 0));
          @(negedge clk);
        end
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] rtt;
    repeat (3) @(negedge clk);
    chk("reset", 0, obs_vec(), pack(0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle", 0, obs_vec(), pack(0, 0, 0, 0, 0));
`ifdef GATE_SWEEP_AUTORESTART_EN
    begin
      int pos, v;
      bit d, p;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 4 * DONE_C; c++) begin
        pos = (c - 1) % DONE_C + 1;
        v   = (pos == DONE_C) ? 3 : (pos - 1) / SLOT;
        d   = (pos == DONE_C);
        p   = (c >= DONE_C);
        chk("autorestart", c, obs_vec(), pack(!d, d, p, 0, v));
        gate_c = gate_a & gate_b;
        @(negedge clk);
      end
    end
`else
    sweep("and_clean", TT_AND, 1'b0, 1'b0, 0);
    sweep("c_tied0", 4'b0000, 1'b0, 1'b0, 0);
    sweep("nand", TT_NAND, 1'b0, 1'b0, 0);
    sweep("and_glitch_repulse", TT_AND, 1'b1, 1'b1, 0);
    sweep("or_rst_vec2", TT_OR, 1'b0, 1'b0, 2 * SLOT + 3);
    sweep("and_after_rst", TT_AND, 1'b0, 1'b0, 0);
    sweep("xor", TT_XOR, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      rtt = 4'($urandom);
      sweep($sformatf("rand%0d_tt%b", i, rtt), rtt, 1'b1, 1'b0, 0);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_same", 0, obs_vec(), pack(0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst_start_not_queued", 1, obs_vec(), pack(0, 0, 0, 0, 0));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
